// File: rtl/instr_fetch_unit_pkg.sv
// ============================================================================
// Module   : instr_fetch_unit_pkg
// Brief    : Shared defaults and helpers for the instruction fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_fetch_unit_pkg;

  localparam int         DEF_ADDR_W  = 9;
  localparam int         DEF_INSTR_W = 12;
  localparam logic [8:0]  RESET_PC   = 9'h000;
  localparam logic [11:0] NOP_INSTR  = 12'h000;

  // Bits needed to hold any count in 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
// ============================================================================
// Module   : instr_fetch_unit_if
// Brief    : ROM, instruction-register and redirect signals of the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_unit_if
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W
);

  logic [ADDR_W-1:0]  rom_addr;
  logic               rom_oe;
  logic [INSTR_W-1:0] rom_data;
  logic               ir_valid;
  logic [INSTR_W-1:0] ir_data;
  logic [ADDR_W-1:0]  ir_pc;
  logic               ir_ready;
  logic               redirect;
  logic [ADDR_W-1:0]  redir_addr;
  logic               fetch_en;

  modport master (
    output rom_addr, rom_oe, ir_valid, ir_data, ir_pc,
    input  rom_data, ir_ready, redirect, redir_addr, fetch_en
  );

  modport slave (
    input  rom_addr, rom_oe, ir_valid, ir_data, ir_pc,
    output rom_data, ir_ready, redirect, redir_addr, fetch_en
  );

endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit_fetch_queue.sv
// ============================================================================
// Module   : fetch_queue
// Brief    : Small synchronous FIFO with flush and occupancy, async clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 2,
  parameter int OCC_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic [OCC_W-1:0] occ
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [OCC_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign do_push = push & (cnt_q < OCC_W'(DEPTH));
  assign do_pop  = pop & (cnt_q != '0);

  // Flush wins over a same-cycle push/pop.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = wdata;
        wr_d        = wr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_d = rd_q + PTR_W'(1);
      end
      cnt_d = cnt_q + OCC_W'(do_push) - OCC_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign rdata = mem_q[rd_q];
  assign occ   = cnt_q;

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Fetch stage: PC, ROM read issue, in-flight tracking, prefetch queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int ROM_LAT = 1,
  parameter int DEPTH   = 2
) (
  input  logic CLK,
  input  logic CLR_n,
  instr_fetch_unit_if.master bus
);

  localparam int OCC_W = cnt_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH + ROM_LAT);
  localparam int ENT_W = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0]              pc_q, pc_d;
  logic                           epoch_q, epoch_d;
  logic                           started_q, started_d;
  logic [ROM_LAT-1:0]             pv_q, pv_d;
  logic [ROM_LAT-1:0]             pe_q, pe_d;
  logic [ROM_LAT-1:0][ADDR_W-1:0] ppc_q, ppc_d;

  logic [OCC_W-1:0] occ;
  logic [ENT_W-1:0] head;
  logic [CNT_W-1:0] in_flight;
  logic [CNT_W-1:0] credit_used;
  logic             q_valid, pop, push, issue;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < ROM_LAT; i++) in_flight = in_flight + CNT_W'(pv_q[i]);
  end

  // Queue slots plus outstanding reads, less the slot freed by this cycle's pop.
  assign q_valid     = (occ != '0);
  assign pop         = q_valid & bus.ir_ready;
  assign credit_used = CNT_W'(occ) + in_flight - CNT_W'(pop);
  assign issue       = started_q & bus.fetch_en & ~bus.redirect
                     & (credit_used < CNT_W'(DEPTH));
  assign push        = pv_q[ROM_LAT-1] & (pe_q[ROM_LAT-1] == epoch_q) & ~bus.redirect;

  always_comb begin
    pc_d      = pc_q;
    epoch_d   = epoch_q;
    started_d = 1'b1;
    pv_d      = pv_q;
    pe_d      = pe_q;
    ppc_d     = ppc_q;
    for (int i = ROM_LAT - 1; i > 0; i--) begin
      pv_d[i]  = pv_q[i-1];
      pe_d[i]  = pe_q[i-1];
      ppc_d[i] = ppc_q[i-1];
    end
    pv_d[0]  = issue;
    pe_d[0]  = epoch_q;
    ppc_d[0] = pc_q;
    if (issue) pc_d = pc_q + ADDR_W'(1);
    // Valid bits are cleared too, so back-to-back redirects cannot re-match an old epoch.
    if (bus.redirect) begin
      pc_d    = bus.redir_addr;
      epoch_d = ~epoch_q;
      pv_d    = '0;
    end
  end

  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      pc_q      <= ADDR_W'(RESET_PC);
      epoch_q   <= 1'b0;
      started_q <= 1'b0;
      pv_q      <= '0;
      pe_q      <= '0;
      ppc_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      epoch_q   <= epoch_d;
      started_q <= started_d;
      pv_q      <= pv_d;
      pe_q      <= pe_d;
      ppc_q     <= ppc_d;
    end
  end

  fetch_queue #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH),
    .OCC_W (OCC_W)
  ) u_queue (
    .clk   (CLK),
    .rst_n (CLR_n),
    .push  (push),
    .wdata ({ppc_q[ROM_LAT-1], bus.rom_data}),
    .pop   (pop),
    .flush (bus.redirect),
    .rdata (head),
    .occ   (occ)
  );

  assign bus.rom_oe   = issue;
  assign bus.rom_addr = pc_q;
  assign bus.ir_valid = q_valid;
  assign {bus.ir_pc, bus.ir_data} = q_valid ? head
                                            : {ADDR_W'(RESET_PC), INSTR_W'(NOP_INSTR)};

endmodule

`default_nettype wire
